writeback_queue: RTL

WRITEBACK_QUEUE -- requirements
Module: writeback_queue

---
 rtl/wb_pkg.sv | 6 +
 rtl/wb_fifo.sv | 43 ++++
 rtl/writeback_queue.sv | 79 +++++++
 3 files changed

// File: rtl/wb_pkg.sv
// wb_pkg: shared widths and default queue depth for the writeback queue
package wb_pkg;
    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;
    localparam int WB_DEPTH   = 4;
endpackage

// File: rtl/wb_fifo.sv
// wb_fifo: circular buffer with occupancy count and flush; storage array is not reset
module wb_fifo #(
    parameter int DEPTH = 4,
    parameter int W = 37,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_flush,
    input  logic          i_push,
    input  logic          i_pop,
    input  logic [W-1:0]  i_data,
    output logic [W-1:0]  o_mem [DEPTH],
    output logic [AW-1:0] o_rd_ptr,
    output logic [AW:0]   o_count
);
    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            r_wr_ptr <= r_wr_ptr + AW'(i_push);
            r_rd_ptr <= r_rd_ptr + AW'(i_pop);
            r_count  <= r_count + (AW+1)'(i_push) - (AW+1)'(i_pop);
        end
    end
    always_ff @(posedge clk) begin
        if (i_push) r_mem[r_wr_ptr] <= i_data;
    end
    assign o_mem    = r_mem;
    assign o_rd_ptr = r_rd_ptr;
    assign o_count  = r_count;
endmodule

// File: rtl/writeback_queue.sv
// writeback_queue: buffers register-file writes with x0 filtering and stall gating.
// Define WB_BYPASS_EN to enable youngest-wins forwarding of queued writes to rs1/rs2.
module writeback_queue
    import wb_pkg::*;
#(
    parameter int DEPTH = WB_DEPTH,
    parameter int XLEN = wb_pkg::XLEN
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [REG_ADDR_W-1:0]   in_rd,
    input  logic [XLEN-1:0]         in_data,
    input  logic                    rf_stall,
    output logic                    rf_we,
    output logic [REG_ADDR_W-1:0]   rf_rd,
    output logic [XLEN-1:0]         rf_write_data,
    input  logic [REG_ADDR_W-1:0]   rs1,
    input  logic [REG_ADDR_W-1:0]   rs2,
    output logic                    fwd1_hit,
    output logic                    fwd2_hit,
    output logic [XLEN-1:0]         fwd1_data,
    output logic [XLEN-1:0]         fwd2_data,
    output logic [$clog2(DEPTH):0]  count
);
    localparam int AW = $clog2(DEPTH);
    localparam int W = REG_ADDR_W + XLEN;
    logic [W-1:0]  w_mem [DEPTH];
    logic [AW-1:0] w_rd_ptr;
    logic [AW:0]   w_count;
    logic          w_push;
    logic          w_empty;
    assign w_empty  = w_count == '0;
    assign in_ready = w_count < (AW+1)'(DEPTH) && !flush;
    // x0 writes are handshaken but dropped here so they never occupy a slot
    assign w_push   = in_valid && in_ready && in_rd != '0;
    assign rf_we    = !w_empty && !rf_stall && !flush;
    assign {rf_rd, rf_write_data} = w_empty ? '0 : w_mem[w_rd_ptr];
    assign count    = w_count;
    wb_fifo #(.DEPTH(DEPTH), .W(W)) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .i_flush  (flush),
        .i_push   (w_push),
        .i_pop    (rf_we),
        .i_data   ({in_rd, in_data}),
        .o_mem    (w_mem),
        .o_rd_ptr (w_rd_ptr),
        .o_count  (w_count)
    );
`ifdef WB_BYPASS_EN
    // Scan oldest to youngest so the last match, the youngest, wins
    always_comb begin
        fwd1_hit  = 1'b0;
        fwd2_hit  = 1'b0;
        fwd1_data = '0;
        fwd2_data = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if ((AW+1)'(k) < w_count && rs1 != '0 && w_mem[w_rd_ptr + AW'(k)][W-1 -: REG_ADDR_W] == rs1) begin
                fwd1_hit  = 1'b1;
                fwd1_data = w_mem[w_rd_ptr + AW'(k)][XLEN-1:0];
            end
            if ((AW+1)'(k) < w_count && rs2 != '0 && w_mem[w_rd_ptr + AW'(k)][W-1 -: REG_ADDR_W] == rs2) begin
                fwd2_hit  = 1'b1;
                fwd2_data = w_mem[w_rd_ptr + AW'(k)][XLEN-1:0];
            end
        end
    end
`else
    logic w_unused;
    assign w_unused  = ^{rs1, rs2};
    assign fwd1_hit  = 1'b0;
    assign fwd2_hit  = 1'b0;
    assign fwd1_data = '0;
    assign fwd2_data = '0;
`endif
endmodule
